// File: rtl/chu_pmod_als_core.sv
// MMIO slot core for the PMOD ALS light sensor: timed SPI conversions feeding a sample FIFO.
// Optional min/max tracking register is built when ALS_MINMAX_EN is defined.
module chu_pmod_als_core #(
    parameter int FIFO_AW  = 4,
    parameter int DVSR_RST = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        pmod_sck,
    output logic        pmod_cs,
    input  logic        pmod_miso
);

    // state | meaning
    // IDLE  | waiting for trigger or pending request, cs high
    // SETUP | cs low, one half-period before the first sck fall
    // SHIFT | 16 sck periods, miso captured at end of each low half
    // HOLD  | cs high quiet time; sample pushed on entry
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} state_t;

    localparam int DEPTH = 2**FIFO_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   lat_q, lat_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   shreg_q, shreg_d;
    logic          sck_q, sck_d;
    logic          ncs_q, ncs_d;
    logic          pend_q, pend_d;

    logic          en_q;
    logic [31:0]   period_q;
    logic [15:0]   dvsr_q;
    logic [31:0]   tmr_q;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q;
    logic               ovf_q;
    logic [7:0]         last_q;

    logic wr_stat, wr_ctrl, wr_per, wr_dvsr;
    logic tmr_tc, trig, busy, push_req;
    logic fifo_empty, fifo_full, pop, push_ok;
    logic [7:0] push_data;

    assign wr_stat = cs & write & (addr == 5'd0);
    assign wr_ctrl = cs & write & (addr == 5'd2);
    assign wr_per  = cs & write & (addr == 5'd3);
    assign wr_dvsr = cs & write & (addr == 5'd4);

    assign tmr_tc = en_q & (tmr_q == '0);
    assign trig   = (wr_ctrl & wr_data[1]) | tmr_tc;
    assign busy   = (state_q != ST_IDLE);

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_FULL);
    assign pop        = cs & read & (addr == 5'd1) & ~fifo_empty;
    assign push_data  = shreg_q[12:5];
    assign push_ok    = push_req & (~fifo_full | pop);

    assign pmod_sck = sck_q;
    assign pmod_cs  = ncs_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q     <= 1'b0;
            period_q <= '0;
            dvsr_q   <= 16'(DVSR_RST);
        end else begin
            if (wr_ctrl) en_q     <= wr_data[0];
            if (wr_per)  period_q <= wr_data;
            if (wr_dvsr) dvsr_q   <= wr_data[15:0];
        end
    end

    // Down-counter reloads while disabled so enabling waits a full period.
    always_ff @(posedge clk) begin
        if (reset)
            tmr_q <= '0;
        else if (!en_q || tmr_q == '0)
            tmr_q <= period_q;
        else
            tmr_q <= tmr_q - 32'd1;
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        lat_d    = lat_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        sck_d    = sck_q;
        ncs_d    = ncs_q;
        pend_d   = pend_q;
        push_req = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (trig || pend_q) begin
                    state_d = ST_SETUP;
                    ncs_d   = 1'b0;
                    lat_d   = dvsr_q;
                    div_d   = dvsr_q;
                    pend_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                if (div_q == '0) begin
                    state_d = ST_SHIFT;
                    sck_d   = 1'b0;
                    div_d   = lat_q;
                    bit_d   = '0;
                end else begin
                    div_d = div_q - 16'd1;
                end
            end
            ST_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - 16'd1;
                end else if (!sck_q) begin
                    shreg_d = {shreg_q[14:0], pmod_miso};
                    sck_d   = 1'b1;
                    div_d   = lat_q;
                end else if (bit_q == 4'd15) begin
                    state_d  = ST_HOLD;
                    ncs_d    = 1'b1;
                    div_d    = lat_q;
                    push_req = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                    sck_d = 1'b0;
                    div_d = lat_q;
                end
            end
            ST_HOLD: begin
                if (div_q == '0)
                    state_d = ST_IDLE;
                else
                    div_d = div_q - 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (busy && trig)
            pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            lat_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sck_q   <= 1'b1;
            ncs_q   <= 1'b1;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            lat_q   <= lat_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sck_q   <= sck_d;
            ncs_q   <= ncs_d;
            pend_q  <= pend_d;
        end
    end

    // A pop on a full FIFO frees the head slot, which is the one written this cycle.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            last_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
            if (push_req && fifo_full && !pop)
                ovf_q <= 1'b1;
            else if (wr_stat)
                ovf_q <= 1'b0;
            if (push_req)
                last_q <= push_data;
        end
    end

`ifdef ALS_MINMAX_EN
    logic       wr_mm;
    logic [7:0] min_q, max_q;

    assign wr_mm = cs & write & (addr == 5'd6);

    always_ff @(posedge clk) begin
        if (reset || wr_mm) begin
            min_q <= 8'hFF;
            max_q <= 8'h00;
        end else if (push_req) begin
            if (push_data < min_q) min_q <= push_data;
            if (push_data > max_q) max_q <= push_data;
        end
    end
`endif

    // Status keeps the FIFO count byte-aligned at bit 8.
    always_comb begin
        rd_data = '0;
        case (addr)
            5'd0: begin
                rd_data[FIFO_AW+8:8] = cnt_q;
                rd_data[3:0]         = {ovf_q, fifo_full, fifo_empty, busy};
            end
            5'd1: begin
                if (!fifo_empty)
                    rd_data[8:0] = {1'b1, mem_q[rd_ptr_q]};
            end
            5'd5: rd_data[7:0] = last_q;
`ifdef ALS_MINMAX_EN
            5'd6: rd_data[15:0] = {max_q, min_q};
`endif
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_chu_pmod_als_core.sv
// Directed bench for chu_pmod_als_core: ADC081S021 serial model plus a sample scoreboard.
module tb_chu_pmod_als_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        pmod_sck;
    logic        pmod_cs;
    logic        miso = 1'b0;

    int n_run = 0;
    int n_fail = 0;

    logic [7:0]  miso_vals[$];
    logic [7:0]  exp_q[$];

    logic        in_frame = 1'b0;
    logic [15:0] frame = '0;
    int          bitk = 0;
    int          sck_falls = 0;
    longint      fall_t[2];

    always #5 clk = ~clk;

    chu_pmod_als_core dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .read      (read),
        .write     (write),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .pmod_sck  (pmod_sck),
        .pmod_cs   (pmod_cs),
        .pmod_miso (miso)
    );

    // ADC model: frame = 3 zeros, 8 data bits, 5 zeros; a new bit after each sck fall.
    always @(negedge pmod_cs or negedge pmod_sck or posedge pmod_cs) begin
        if (pmod_cs) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            in_frame = 1'b1;
            frame    = {3'b000, (miso_vals.size() > 0) ? miso_vals.pop_front() : 8'h00, 5'b00000};
            bitk     = 0;
            miso     = 1'b0;
        end else begin
            if (bitk < 2) fall_t[bitk] = $time;
            if (bitk < 16) miso = frame[15 - bitk];
            bitk      = bitk + 1;
            sck_falls = sck_falls + 1;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: observed no finish, required finish within 60000 cycles");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic reg_rd(input logic [4:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        cs = 1'b1; read = 1'b1; addr = a;
        #2 d = rd_data;
        @(posedge clk); #1;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] d);
        addr = a;
        #1 d = rd_data;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] d, e;
        e = '0;
        if (exp_q.size() > 0) e = {23'd0, 1'b1, exp_q.pop_front()};
        reg_rd(5'd1, d);
        check(tag, d, e);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] e);
        logic [31:0] d;
        reg_rd(a, d);
        check(tag, d, e);
    endtask

    // Idle must hold for two polls: back-to-back frames show a single idle cycle.
    task automatic wait_idle(input string tag, input int bound);
        int quiet = 0;
        int n = 0;
        logic [31:0] st;
        while (quiet < 2 && n < bound) begin
            @(negedge clk);
            peek(5'd0, st);
            if (st[0]) quiet = 0; else quiet++;
            n++;
        end
        check(tag, 32'(quiet >= 2), 32'd1);
    endtask

    task automatic wait_mask(input string tag, input logic [31:0] mask, input int bound,
                             output logic [31:0] st);
        int n = 0;
        st = '0;
        while (((st & mask) != mask) && n < bound) begin
            @(negedge clk);
            peek(5'd0, st);
            n++;
        end
        check(tag, st & mask, mask);
    endtask

    task automatic one_shot(input logic [7:0] v);
        miso_vals.push_back(v);
        exp_q.push_back(v);
        reg_wr(5'd2, 32'h2);
        wait_idle("shot_idle", 2000);
    endtask

    initial begin
        logic [31:0] st;
        int low, n, f0;

        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_cs", 32'(pmod_cs), 32'd1);
        check("rst_sck", 32'(pmod_sck), 32'd1);
        rd_check("rst_status", 5'd0, 32'h2);
        rd_check("rst_head", 5'd1, 32'h0);
        rd_check("rst_last", 5'd5, 32'h0);
`ifdef ALS_MINMAX_EN
        rd_check("rst_minmax", 5'd6, 32'h0000_00FF);
`else
        rd_check("rst_reg6", 5'd6, 32'h0);
`endif

        // single shot with frame timing
        miso_vals.push_back(8'hA5);
        exp_q.push_back(8'hA5);
        f0 = sck_falls;
        reg_wr(5'd2, 32'h2);
        low = 0;
        n = 0;
        do begin
            @(negedge clk);
            if (!pmod_cs) low++;
            n++;
        end while ((!pmod_cs || low == 0) && n < 2000);
        check("cs_low_len", 32'(low), 32'd825);
        check("sck_falls", 32'(sck_falls - f0), 32'd16);
        check("sck_period", 32'(fall_t[1] - fall_t[0]), 32'd500);
        wait_idle("shot_idle", 200);
        pop_check("shot_pop");
        rd_check("shot_empty", 5'd0, 32'h2);
        rd_check("shot_last", 5'd5, 32'hA5);
        pop_check("empty_pop");

        // three triggers in one frame -> two frames
        miso_vals.push_back(8'h3C); exp_q.push_back(8'h3C);
        miso_vals.push_back(8'h5A); exp_q.push_back(8'h5A);
        reg_wr(5'd2, 32'h2);
        reg_wr(5'd2, 32'h2);
        reg_wr(5'd2, 32'h2);
        repeat (2700) @(posedge clk);
        rd_check("trig3_status", 5'd0, 32'h200);
        pop_check("trig3_pop0");
        pop_check("trig3_pop1");

        // min/max tracking
        reg_wr(5'd6, 32'h0);
        one_shot(8'h10);
        one_shot(8'hF0);
        one_shot(8'h80);
`ifdef ALS_MINMAX_EN
        rd_check("minmax", 5'd6, 32'h0000_F010);
`else
        rd_check("reg6_zero", 5'd6, 32'h0);
`endif
        rd_check("mm_last", 5'd5, 32'h80);
        rd_check("mm_status", 5'd0, 32'h300);
        for (int i = 0; i < 3; i++) pop_check($sformatf("mm_pop%0d", i));

        // overflow with back-to-back conversions
        for (int i = 0; i < 17; i++) begin
            miso_vals.push_back(8'(8'h40 + i));
            if (i < 16) exp_q.push_back(8'(8'h40 + i));
        end
        reg_wr(5'd3, 32'd0);
        reg_wr(5'd2, 32'h1);
        wait_mask("ovf_wait_full", 32'h4, 16000, st);
        check("ovf_full_status", st & 32'hFFFF_FFFE, 32'h1004);
        wait_mask("ovf_wait_ovf", 32'h8, 2000, st);
        reg_wr(5'd2, 32'h0);
        wait_idle("ovf_idle", 3000);
        rd_check("ovf_set", 5'd0, 32'h100C);
        reg_wr(5'd0, 32'h0);
        rd_check("ovf_clr", 5'd0, 32'h1004);

        // pop on the push cycle of a full FIFO
        miso_vals.push_back(8'h77);
        exp_q.push_back(8'h77);
        reg_wr(5'd2, 32'h2);
        repeat (823) @(posedge clk);
        pop_check("coll_pop");
        wait_idle("coll_idle", 200);
        rd_check("coll_status", 5'd0, 32'h1004);
        for (int i = 0; i < 16; i++) pop_check($sformatf("coll_drain%0d", i));
        rd_check("coll_empty", 5'd0, 32'h2);

        // periodic sampling, one trigger every 1000 cycles
        for (int i = 1; i <= 10; i++) begin
            miso_vals.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        reg_wr(5'd3, 32'd999);
        reg_wr(5'd2, 32'h1);
        repeat (10500) @(posedge clk);
        reg_wr(5'd2, 32'h0);
        repeat (1000) @(posedge clk);
        rd_check("per_status", 5'd0, 32'hA00);
        for (int i = 0; i < 10; i++) pop_check($sformatf("per_pop%0d", i));

        // reset in the middle of bit 7
        one_shot(8'h66);
        miso_vals.push_back(8'h99);
        reg_wr(5'd2, 32'h2);
        repeat (380) @(posedge clk);
        #1;
        check("mid_sck_low", 32'(pmod_sck), 32'd0);
        check("mid_cs_low", 32'(pmod_cs), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mrst_cs", 32'(pmod_cs), 32'd1);
        check("mrst_sck", 32'(pmod_sck), 32'd1);
        peek(5'd0, st);
        check("mrst_status", st, 32'h2);
        reset = 1'b0;
        exp_q.delete();
        miso_vals.delete();
        pop_check("mrst_head");
        one_shot(8'h5A);
        pop_check("post_rst_pop");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
